// File: rtl/matmul_mac_sequencer.sv
// Issue sequencer for the shared MAC: walks (i,j,k) with k innermost, drives
// operand addresses and MAC control, and times each C write to the MAC latency.
module matmul_mac_sequencer #(
  parameter int N       = 4,
  parameter int IDX_W   = 2,
  parameter int MAC_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [2*IDX_W-1:0] a_addr,
  output logic [2*IDX_W-1:0] b_addr,
  output logic               mac_en,
  output logic               mac_clr,
  output logic               mac_last,
  output logic               c_we,
  output logic [2*IDX_W-1:0] c_addr
);

  localparam int DW = $clog2(MAC_LAT + 1);
  localparam logic [IDX_W-1:0] IMAX  = IDX_W'(N - 1);
  localparam logic [DW-1:0]    DLAST = DW'(MAC_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] i_q, j_q, k_q, i_n, j_n, k_n;
  logic [DW-1:0]    dcnt_q, dcnt_n;

  logic               busy_d, done_d, en_d, clr_d, last_d;
  logic [2*IDX_W-1:0] a_d, b_d;

  logic               vld_pipe [MAC_LAT:1];
  logic [2*IDX_W-1:0] adr_pipe [MAC_LAT:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      dcnt_q <= '0;
    end else begin
      state  <= state_n;
      i_q    <= i_n;
      j_q    <= j_n;
      k_q    <= k_n;
      dcnt_q <= dcnt_n;
    end
  end

  // Counters hold the issue being presented; all-ones wrap returns them to 0
  // on the final issue, so DRAIN and IDLE see cleared indices.
  always_comb begin
    state_n = state;
    i_n     = i_q;
    j_n     = j_q;
    k_n     = k_q;
    dcnt_n  = '0;
    if (abort) begin
      state_n = IDLE;
      i_n     = '0;
      j_n     = '0;
      k_n     = '0;
    end else begin
      case (state)
        IDLE: if (start) state_n = RUN;
        RUN: begin
          k_n = k_q + 1'b1;
          if (k_q == IMAX) begin
            j_n = j_q + 1'b1;
            if (j_q == IMAX) begin
              i_n = i_q + 1'b1;
              if (i_q == IMAX) state_n = DRAIN;
            end
          end
        end
        DRAIN: begin
          dcnt_n = dcnt_q + 1'b1;
          if (dcnt_q == DLAST) begin
            state_n = DONE;
            dcnt_n  = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they land in registers aligned
  // with the state they describe.
  always_comb begin
    en_d   = (state_n == RUN);
    clr_d  = en_d && (k_n == '0);
    last_d = en_d && (k_n == IMAX);
    a_d    = en_d ? {i_n, k_n} : '0;
    b_d    = en_d ? {k_n, j_n} : '0;
    busy_d = (state_n == RUN) || (state_n == DRAIN);
    done_d = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      mac_en   <= 1'b0;
      mac_clr  <= 1'b0;
      mac_last <= 1'b0;
      a_addr   <= '0;
      b_addr   <= '0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      mac_en   <= en_d;
      mac_clr  <= clr_d;
      mac_last <= last_d;
      a_addr   <= a_d;
      b_addr   <= b_d;
    end
  end

  // Stage 1 captures the presented mac_last, so the tail is MAC_LAT cycles late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 1; s <= MAC_LAT; s++) begin
        vld_pipe[s] <= 1'b0;
        adr_pipe[s] <= '0;
      end
    end else if (abort) begin
      for (int s = 1; s <= MAC_LAT; s++) begin
        vld_pipe[s] <= 1'b0;
        adr_pipe[s] <= '0;
      end
    end else begin
      vld_pipe[1] <= mac_last;
      adr_pipe[1] <= mac_last ? {a_addr[2*IDX_W-1:IDX_W], b_addr[IDX_W-1:0]} : '0;
      for (int s = 2; s <= MAC_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        adr_pipe[s] <= adr_pipe[s-1];
      end
    end
  end

  assign c_we   = vld_pipe[MAC_LAT];
  assign c_addr = adr_pipe[MAC_LAT];

endmodule

// File: tb/tb_matmul_mac_sequencer.sv
// Bench for matmul_mac_sequencer: two instances (N=4/LAT=2, N=2/LAT=1) checked
// every cycle against an index-arithmetic model, plus literal spot checks.
module tb_matmul_mac_sequencer;
  localparam int N1 = 4, L1 = 2, W1 = 2;
  localparam int N2 = 2, L2 = 1, W2 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, abort = 1'b0, start2 = 1'b0, abort2 = 1'b0;

  logic busy1, done1, en1, clr1, last1, we1;
  logic [2*W1-1:0] a1, b1, c1;
  logic busy2, done2, en2, clr2, last2, we2;
  logic [2*W2-1:0] a2, b2, c2;

  matmul_mac_sequencer #(.N(N1), .IDX_W(W1), .MAC_LAT(L1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy1), .done(done1), .a_addr(a1), .b_addr(b1),
    .mac_en(en1), .mac_clr(clr1), .mac_last(last1), .c_we(we1), .c_addr(c1));

  matmul_mac_sequencer #(.N(N2), .IDX_W(W2), .MAC_LAT(L2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .busy(busy2), .done(done2), .a_addr(a2), .b_addr(b2),
    .mac_en(en2), .mac_clr(clr2), .mac_last(last2), .c_we(we2), .c_addr(c2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, fails = 0;

  typedef struct {
    bit busy, done, en, clr, last, we;
    int a, b, c;
  } exp_t;

  // Expected outputs d cycles after start was sampled, from the loop nest.
  function automatic exp_t model(int n, int lat, bit act, int s, int t);
    exp_t e = '{default: 0};
    int d, m, w, n3;
    n3 = n * n * n;
    d  = t - s;
    if (!act || d < 1) return e;
    if (d <= n3) begin
      m      = d - 1;
      e.en   = 1;
      e.clr  = (m % n) == 0;
      e.last = (m % n) == n - 1;
      e.a    = (m / (n * n)) * n + (m % n);
      e.b    = (m % n) * n + ((m / n) % n);
    end
    w = d - 1 - lat;
    if (w >= 0 && w < n3 && (w % n) == n - 1) begin
      e.we = 1;
      e.c  = w / n;
    end
    e.busy = d <= n3 + lat;
    e.done = d == n3 + lat + 1;
    return e;
  endfunction

  function automatic bit same(exp_t x, exp_t y);
    return x.busy == y.busy && x.done == y.done && x.en == y.en && x.clr == y.clr &&
           x.last == y.last && x.we == y.we && x.a == y.a && x.b == y.b && x.c == y.c;
  endfunction

  task automatic cmp(string name, exp_t g, exp_t e);
    checks++;
    if (!same(g, e)) begin
      fails++;
      $display("FAIL %s cyc%0d: got busy=%0d done=%0d en=%0d clr=%0d last=%0d a=%0d b=%0d we=%0d c=%0d; want busy=%0d done=%0d en=%0d clr=%0d last=%0d a=%0d b=%0d we=%0d c=%0d",
               name, cyc, g.busy, g.done, g.en, g.clr, g.last, g.a, g.b, g.we, g.c,
               e.busy, e.done, e.en, e.clr, e.last, e.a, e.b, e.we, e.c);
    end
  endtask

  task automatic check_lit(string name, int got, int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s cyc%0d: got %0d want %0d", name, cyc, got, want);
    end
  endtask

  // Per-cycle compare; model run state advances from the inputs seen this cycle.
  bit act1 = 0, act2 = 0;
  int s1 = 0, s2 = 0;
  initial begin
    exp_t g;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act1 = 0;
        act2 = 0;
      end
      g = '{busy: busy1, done: done1, en: en1, clr: clr1, last: last1, we: we1,
            a: int'(a1), b: int'(b1), c: int'(c1)};
      cmp("dut1", g, model(N1, L1, act1, s1, cyc));
      g = '{busy: busy2, done: done2, en: en2, clr: clr2, last: last2, we: we2,
            a: int'(a2), b: int'(b2), c: int'(c2)};
      cmp("dut2", g, model(N2, L2, act2, s2, cyc));
      if (rst_n) begin
        if (abort) act1 = 0;
        else if (start && (!act1 || cyc - s1 > N1 * N1 * N1 + L1 + 1)) begin
          act1 = 1;
          s1   = cyc;
        end
        if (abort2) act2 = 0;
        else if (start2 && (!act2 || cyc - s2 > N2 * N2 * N2 + L2 + 1)) begin
          act2 = 1;
          s2   = cyc;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nwr;
    repeat (3) step();
    check_lit("rst_busy", busy1, 0);
    check_lit("rst_en", en1, 0);
    check_lit("rst_we", we1, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Full run with stray start pulses in RUN and DONE.
    nwr = 0;
    for (int r = 0; r <= 75; r++) begin
      start = (r == 0 || r == 30 || r == 67);
      if (we1) nwr++;
      case (r)
        1:  begin check_lit("first_en", en1, 1); check_lit("first_clr", clr1, 1); end
        6:  begin check_lit("a_c6", a1, 1); check_lit("b_c6", b1, 5);
                  check_lit("we_c6", we1, 1); check_lit("caddr_c6", c1, 0); end
        10: begin check_lit("we_c10", we1, 1); check_lit("caddr_c10", c1, 1); end
        64: check_lit("last_c64", last1, 1);
        66: begin check_lit("we_c66", we1, 1); check_lit("caddr_c66", c1, 15); end
        67: begin check_lit("done_c67", done1, 1); check_lit("busy_c67", busy1, 0); end
        68: check_lit("done_c68", done1, 0);
        default: ;
      endcase
      step();
    end
    check_lit("wr_count", nwr, 16);
    start = 1'b0;

    // Held start relaunches after DONE; then abort mid-run.
    for (int r = 0; r <= 72; r++) begin
      start = (r <= 69);
      abort = (r == 70);
      case (r)
        68: check_lit("held_idle_c68", en1, 0);
        69: begin check_lit("held_en_c69", en1, 1); check_lit("held_a_c69", a1, 0); end
        71: begin check_lit("abort_en", en1, 0); check_lit("abort_busy", busy1, 0); end
        default: ;
      endcase
      step();
    end
    start = 1'b0;
    abort = 1'b0;

    // Abort at 20, restart at 25.
    for (int r = 0; r <= 95; r++) begin
      start = (r == 0 || r == 25);
      abort = (r == 20);
      case (r)
        20: check_lit("pre_abort_en", en1, 1);
        21: begin check_lit("post_abort_en", en1, 0); check_lit("post_abort_busy", busy1, 0); end
        26: check_lit("restart_clr", clr1, 1);
        92: check_lit("restart_done", done1, 1);
        default: ;
      endcase
      step();
    end
    start = 1'b0;
    abort = 1'b0;

    // Asynchronous reset in the middle of cycle 40.
    for (int r = 0; r < 40; r++) begin
      start = (r == 0);
      step();
    end
    start = 1'b0;
    check_lit("pre_rst_en", en1, 1);
    #3 rst_n = 1'b0;
    #1;
    check_lit("async_rst_en", en1, 0);
    check_lit("async_rst_busy", busy1, 0);
    check_lit("async_rst_a", a1, 0);
    step();
    step();
    rst_n = 1'b1;
    repeat (6) step();
    check_lit("idle_after_rst", busy1, 0);

    // Small instance: N=2, MAC_LAT=1.
    for (int r = 0; r <= 12; r++) begin
      start2 = (r == 0);
      case (r)
        1:  check_lit("n2_en_c1", en2, 1);
        2:  check_lit("n2_last_c2", last2, 1);
        3:  begin check_lit("n2_we_c3", we2, 1); check_lit("n2_caddr_c3", c2, 0); end
        8:  check_lit("n2_last_c8", last2, 1);
        9:  begin check_lit("n2_we_c9", we2, 1); check_lit("n2_caddr_c9", c2, 3); end
        10: check_lit("n2_done_c10", done2, 1);
        default: ;
      endcase
      step();
    end
    start2 = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
